// File: rtl/inst_fetch.sv
// inst_fetch: byte-serial instruction fetch stage feeding the IF/ID register
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  input  logic        mem_grant_i,
  input  logic [7:0]  mem_din_i,
  output logic        mem_rd_o,
  output logic [31:0] mem_addr_o,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o
);
  localparam logic [2:0] REQ = 3'd0, B1 = 3'd1, B2 = 3'd2, B3 = 3'd3, B4 = 3'd4, DONE = 3'd5;
  logic [2:0]  state;
  logic [2:0]  state_nxt;
  logic [31:0] pc;
  logic [23:0] byte_buf;
  always_comb begin
    state_nxt = state == REQ ? (mem_grant_i ? B1 : REQ) : state == DONE ? (stall_i ? DONE : REQ) : state + 3'd1;
  end
  assign mem_rd_o   = rst && state <= B3;
  assign mem_addr_o = !rst ? RESET_PC : pc + {30'd0, state <= B3 ? state[1:0] : 2'd0};
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= REQ;
      pc           <= RESET_PC;
      byte_buf     <= '0;
      inst_o       <= '0;
      pc_o         <= '0;
      inst_valid_o <= 1'b0;
    end else if (branch_flag_i) begin
      state        <= REQ;
      pc           <= branch_target_i & ~32'd3;
      inst_valid_o <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == B1) byte_buf[7:0] <= mem_din_i;
      if (state == B2) byte_buf[15:8] <= mem_din_i;
      if (state == B3) byte_buf[23:16] <= mem_din_i;
      if (state == B4) begin
        inst_o       <= {mem_din_i, byte_buf};
        pc_o         <= pc;
        inst_valid_o <= 1'b1;
      end
      if (state == DONE && !stall_i) begin
        pc           <= pc + 32'd4;
        inst_valid_o <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: vector table, directed corner cases and random checks against a fetch model
module tb_inst_fetch;
  typedef struct {
    logic        rst;
    logic        stall;
    logic        br;
    logic        grant;
    logic [31:0] tgt;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] addr1;
    logic        v;
    logic [31:0] inst;
    logic [31:0] pco;
  } vec_t;
  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i;
  logic        branch_flag_i;
  logic        mem_grant_i;
  logic [31:0] branch_target_i;
  logic [7:0]  din [2];
  logic        rd [2];
  logic        v [2];
  logic [31:0] addr [2];
  logic [31:0] inst [2];
  logic [31:0] pco [2];
  logic [7:0]  mem [512];
  logic [31:0] m_pc [2];
  logic [31:0] m_inst [2];
  logic [31:0] m_pco [2];
  logic        m_v [2];
  int          m_k [2];
  int          errors = 0;
  int          checks = 0;
  vec_t        tbl [9];
  always #5 clk = ~clk;
  inst_fetch #(.RESET_PC(32'h0000_0000)) dut0 (
    .clk(clk), .rst(rst), .stall_i(stall_i), .branch_flag_i(branch_flag_i),
    .branch_target_i(branch_target_i), .mem_grant_i(mem_grant_i), .mem_din_i(din[0]),
    .mem_rd_o(rd[0]), .mem_addr_o(addr[0]), .inst_valid_o(v[0]), .inst_o(inst[0]), .pc_o(pco[0])
  );
  inst_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut1 (
    .clk(clk), .rst(rst), .stall_i(stall_i), .branch_flag_i(branch_flag_i),
    .branch_target_i(branch_target_i), .mem_grant_i(mem_grant_i), .mem_din_i(din[1]),
    .mem_rd_o(rd[1]), .mem_addr_o(addr[1]), .inst_valid_o(v[1]), .inst_o(inst[1]), .pc_o(pco[1])
  );
  function automatic logic [31:0] rpc(int i);
    return i == 0 ? 32'h0000_0000 : 32'hFFFF_FFFC;
  endfunction
  function automatic logic [7:0] mem_byte(logic [31:0] a);
    return a < 32'd512 ? mem[a[8:0]] : a[7:0] ^ a[31:24] ^ 8'hA5;
  endfunction
  function automatic logic [31:0] word(logic [31:0] a);
    return {mem_byte(a + 32'd3), mem_byte(a + 32'd2), mem_byte(a + 32'd1), mem_byte(a)};
  endfunction
  function automatic logic [31:0] exp_addr(int i);
    return !rst ? rpc(i) : m_pc[i] + ((m_k[i] >= 0 && m_k[i] < 3) ? 32'(m_k[i] + 1) : 32'd0);
  endfunction
  function automatic void model_edge(int i);
    if (!rst) begin
      m_pc[i] = rpc(i);
      m_k[i] = -1;
      m_v[i] = 1'b0;
      m_inst[i] = '0;
      m_pco[i] = '0;
    end else if (branch_flag_i) begin
      m_pc[i] = {branch_target_i[31:2], 2'b00};
      m_k[i] = -1;
      m_v[i] = 1'b0;
    end else if (m_k[i] < 0) begin
      m_k[i] = mem_grant_i ? 0 : -1;
    end else if (m_k[i] < 3) begin
      m_k[i] = m_k[i] + 1;
    end else if (m_k[i] == 3) begin
      m_k[i] = 4;
      m_v[i] = 1'b1;
      m_inst[i] = word(m_pc[i]);
      m_pco[i] = m_pc[i];
    end else if (!stall_i) begin
      m_pc[i] = m_pc[i] + 32'd4;
      m_k[i] = -1;
      m_v[i] = 1'b0;
    end
  endfunction
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", n, act, want, $time);
    end
  endtask
  task automatic step();
    logic [31:0] a [2];
    #1;
    for (int i = 0; i < 2; i++) begin
      a[i] = addr[i];
      chk($sformatf("dut%0d_rd", i), 32'(rd[i]), 32'(rst && (m_k[i] < 3)));
      chk($sformatf("dut%0d_addr", i), addr[i], exp_addr(i));
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) model_edge(i);
    #1;
    for (int i = 0; i < 2; i++) begin
      din[i] = mem_byte(a[i]);
      chk($sformatf("dut%0d_valid", i), 32'(v[i]), 32'(m_v[i]));
      chk($sformatf("dut%0d_inst", i), inst[i], m_inst[i]);
      chk($sformatf("dut%0d_pc", i), pco[i], m_pco[i]);
    end
  endtask
  initial begin
    int n;
    logic [31:0] held_pc;
    for (int i = 0; i < 512; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h13;
    mem[1] = 8'h05;
    mem[2] = 8'h10;
    mem[3] = 8'h00;
    for (int i = 0; i < 2; i++) begin
      din[i] = 8'h00;
      m_pc[i] = rpc(i);
      m_k[i] = -1;
      m_v[i] = 1'b0;
      m_inst[i] = '0;
      m_pco[i] = '0;
    end
    tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 32'h0, 32'hFFFF_FFFC, 1'b0, 32'h0, 32'h0};
    tbl[1] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 32'h0, 32'hFFFF_FFFC, 1'b0, 32'h0, 32'h0};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 1'b1, 32'h0, 32'hFFFF_FFFC, 1'b0, 32'h0, 32'h0};
    tbl[3] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 1'b1, 32'h1, 32'hFFFF_FFFD, 1'b0, 32'h0, 32'h0};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 1'b1, 32'h2, 32'hFFFF_FFFE, 1'b0, 32'h0, 32'h0};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 1'b1, 32'h3, 32'hFFFF_FFFF, 1'b0, 32'h0, 32'h0};
    tbl[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 32'h0, 32'hFFFF_FFFC, 1'b1, 32'h0010_0513, 32'h0};
    tbl[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 32'h0, 32'hFFFF_FFFC, 1'b0, 32'h0010_0513, 32'h0};
    tbl[8] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 1'b1, 32'h4, 32'h0000_0000, 1'b0, 32'h0010_0513, 32'h0};
    foreach (tbl[j]) begin
      rst = tbl[j].rst;
      stall_i = tbl[j].stall;
      branch_flag_i = tbl[j].br;
      mem_grant_i = tbl[j].grant;
      branch_target_i = tbl[j].tgt;
      #1;
      chk("tbl_rd", 32'(rd[0]), 32'(tbl[j].rd));
      chk("tbl_addr", addr[0], tbl[j].addr);
      chk("tbl_wrap_addr", addr[1], tbl[j].addr1);
      step();
      chk("tbl_valid", 32'(v[0]), 32'(tbl[j].v));
      chk("tbl_inst", inst[0], tbl[j].inst);
      chk("tbl_pc", pco[0], tbl[j].pco);
    end
    n = 0;
    while (!v[0] && n < 10) begin
      step();
      n++;
    end
    chk("stall_reach_done", 32'(v[0]), 32'd1);
    held_pc = m_pco[0];
    stall_i = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      chk("stall_valid_hold", 32'(v[0]), 32'd1);
      chk("stall_rd_low", 32'(rd[0]), 32'd0);
      chk("stall_inst_hold", inst[0], word(32'h4));
    end
    stall_i = 1'b0;
    step();
    chk("stall_release_valid", 32'(v[0]), 32'd0);
    chk("stall_release_pc", addr[0], held_pc + 32'd4);
    mem_grant_i = 1'b0;
    for (int c = 0; c < 7; c++) begin
      step();
      chk("deny_rd", 32'(rd[0]), 32'd1);
      chk("deny_addr", addr[0], 32'h8);
    end
    mem_grant_i = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (!v[0] && n < 20);
    chk("grant_latency", 32'(n), 32'd5);
    chk("grant_inst", inst[0], word(32'h8));
    step();
    step();
    step();
    branch_flag_i = 1'b1;
    branch_target_i = 32'h0000_0103;
    step();
    branch_flag_i = 1'b0;
    chk("br_addr", addr[0], 32'h100);
    chk("br_valid", 32'(v[0]), 32'd0);
    n = 0;
    while (!v[0] && n < 20) begin
      step();
      n++;
    end
    chk("br_latency", 32'(n), 32'd5);
    chk("br_inst", inst[0], word(32'h100));
    chk("br_pc", pco[0], 32'h100);
    step();
    step();
    step();
    step();
    rst = 1'b0;
    step();
    chk("rst_valid", 32'(v[0]), 32'd0);
    chk("rst_inst", inst[0], 32'd0);
    chk("rst_pc", pco[0], 32'd0);
    chk("rst_rd", 32'(rd[0]), 32'd0);
    rst = 1'b1;
    #1;
    chk("rst_restart_addr", addr[0], 32'h0);
    chk("rst_restart_rd", 32'(rd[0]), 32'd1);
    for (int c = 0; c < 3000; c++) begin
      rst = $urandom_range(99) != 0;
      stall_i = $urandom_range(2) == 0;
      mem_grant_i = $urandom_range(9) < 6;
      branch_flag_i = $urandom_range(19) == 0;
      branch_target_i = $urandom_range(3) == 0 ? $urandom : 32'($urandom_range(511));
      step();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
